// File: rtl/counter_pkg.sv
// counter_pkg: shared types and elaboration-time helpers for the modulo
// counter library.
//   dir_e       : count direction encoding (DIR_DOWN / DIR_UP)
//   modulus_ok  : legality check for a WIDTH / MODULUS pairing
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // True when MODULUS fits in a WIDTH-bit register and has at least two
   // states; WIDTH itself is limited to 1..32.
   function automatic bit modulus_ok(input int width, input longint modulus);
      return (width >= 1) && (width <= 32) &&
             (modulus >= 2) && (modulus <= (longint'(1) << width));
   endfunction

endpackage

// File: rtl/cnt_step.sv
// cnt_step: combinational next-count and bound-crossing logic for one
// modulo counter digit.
//   count_i  : current count (always < MODULUS)
//   up_dn_i  : 1 = up, 0 = down
//   next_o   : count after one step (wrapped or held at the bound)
//   cross_o  : the step attempted to move past 0 or MODULUS-1
module cnt_step
   import counter_pkg::*;
#(
   parameter int     WIDTH    = 4,
   parameter longint MODULUS  = 10,
   parameter bit     SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic             up_dn_i,
   output logic [WIDTH-1:0] next_o,
   output logic             cross_o
);

   // One extra bit so MODULUS = 2^WIDTH still has a representable top value.
   localparam logic [WIDTH:0] MAX_C = (WIDTH+1)'(MODULUS - 1);

   dir_e             dir;
   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   sum;

   assign dir     = dir_e'(up_dn_i);
   assign cnt_ext = {1'b0, count_i};

   always_comb begin
      sum     = cnt_ext;
      cross_o = 1'b0;
      if (dir == DIR_UP) begin
         if (cnt_ext >= MAX_C) begin
            cross_o = 1'b1;
            sum     = SATURATE ? cnt_ext : '0;
         end else begin
            sum = cnt_ext + (WIDTH+1)'(1);
         end
      end else begin
         if (cnt_ext == '0) begin
            cross_o = 1'b1;
            sum     = SATURATE ? cnt_ext : MAX_C;
         end else begin
            sum = cnt_ext - (WIDTH+1)'(1);
         end
      end
   end

   // sum never exceeds MAX_C, so the top bit is always zero here.
   assign next_o = sum[WIDTH-1:0];

endmodule

// File: rtl/mod_counter.sv
// mod_counter: parametrised synchronous up/down modulo counter with
// parallel load, wrap/saturate mode, cascadable terminal count and a
// sticky overflow flag.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   en         : count enable, one step per enabled cycle
//   up_dn      : direction, 1 = up, 0 = down
//   load       : parallel load (overrides en)
//   load_val   : value to load, clamped to MODULUS-1
//   clr_ovf    : clears ovf unless a crossing occurs in the same cycle
//   count      : registered count, 0..MODULUS-1
//   tc         : combinational terminal count (includes en, for cascading)
//   wrap_pulse : registered, high for one cycle after a wrap
//   ovf        : registered sticky overflow/underflow flag
module mod_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH    = 4,
   parameter longint MODULUS  = 10,
   parameter bit     SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap_pulse,
   output logic             ovf
);

   localparam logic [WIDTH:0] MAX_C = (WIDTH+1)'(MODULUS - 1);

   if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_params
      $error("mod_counter: illegal WIDTH/MODULUS combination");
   end

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] step_next;
   logic             step_cross;
   logic [WIDTH-1:0] load_clamped;
   logic             crossing;

   cnt_step #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .SATURATE (SATURATE)
   ) u_step (
      .count_i (count_q),
      .up_dn_i (up_dn),
      .next_o  (step_next),
      .cross_o (step_cross)
   );

   assign load_clamped = ({1'b0, load_val} > MAX_C) ? MAX_C[WIDTH-1:0] : load_val;

   // A crossing only counts when a step actually happens (load has priority).
   assign crossing = !load && en && step_cross;

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q;
      if (load) begin
         count_d = load_clamped;
      end else if (en) begin
         count_d = step_next;
         wrap_d  = step_cross && !SATURATE;
      end
      // Set wins over clear when both happen in the same cycle.
      if (crossing) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   // Unregistered so a chain of digits ripples within a single cycle.
   assign tc = en & (up_dn ? ({1'b0, count_q} == MAX_C) : (count_q == '0));

   assign count      = count_q;
   assign wrap_pulse = wrap_q;
   assign ovf        = ovf_q;

endmodule
